node_eval: RTL and testbench

NODE_EVAL -- requirements
Module: node_eval

---
 rtl/node_eval_if.sv | 29 ++
 rtl/node_eval.sv | 147 ++++++++++++++
 tb/tb_node_eval.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/node_eval_if.sv
// Handshake and data bundle between a tree walker and one node evaluator.
// The walker holds the master side; the evaluator holds the slave side.
interface node_eval_if #(
   parameter int FEATURES         = 3,
   parameter int SAMPLE_BIT_DEPTH = 8,
   parameter int COEFF_BIT_DEPTH  = 4,
   parameter int BIAS_BIT_DEPTH   = 10
);
   logic                                   in_valid;
   logic [FEATURES*SAMPLE_BIT_DEPTH-1:0]   features;
   logic                                   in_ready;
   logic                                   coeff_valid;
   logic signed [COEFF_BIT_DEPTH-1:0]      coeff;
   logic                                   is_one;
   logic signed [BIAS_BIT_DEPTH-1:0]       bias;
   logic                                   tree_done;
   logic                                   next;
   logic                                   child_direction;

   modport master (
      output in_valid, features, coeff_valid, coeff, is_one, bias, tree_done,
      input  in_ready, next, child_direction
   );

   modport slave (
      input  in_valid, features, coeff_valid, coeff, is_one, bias, tree_done,
      output in_ready, next, child_direction
   );
endinterface

// File: rtl/node_eval.sv
// Decision-tree node evaluator: accumulates bias + sum(feature*coeff) over
// FEATURES beats against a held sample and reports the sign as the branch.
module node_eval #(
   parameter int FEATURES         = 3,
   parameter int COEFF_BIT_DEPTH  = 4,
   parameter int BIAS_BIT_DEPTH   = 10,
   parameter int SAMPLE_BIT_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   node_eval_if.slave bus
);

   localparam int PROD_W        = SAMPLE_BIT_DEPTH + COEFF_BIT_DEPTH;
   localparam int BASE_W        = (PROD_W > BIAS_BIT_DEPTH) ? PROD_W : BIAS_BIT_DEPTH;
   localparam int ACC_BIT_DEPTH = BASE_W + $clog2(FEATURES + 1) + 1;
   localparam int BEAT_W        = (FEATURES > 1) ? $clog2(FEATURES) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FEATURES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DECIDE = 2'd2
   } state_t;

   state_t                                state_p0, state_nxt;
   logic [FEATURES*SAMPLE_BIT_DEPTH-1:0]  sample_p0, sample_nxt;
   logic signed [ACC_BIT_DEPTH-1:0]       acc_p0, acc_nxt;
   logic [BEAT_W-1:0]                     beat_p0, beat_nxt;
   logic                                  vld_p1, vld_nxt;
   logic                                  dir_p1, dir_nxt;

   logic signed [SAMPLE_BIT_DEPTH-1:0]    feat_sel;
   logic signed [ACC_BIT_DEPTH-1:0]       acc_base;
   logic signed [ACC_BIT_DEPTH-1:0]       acc_sum;

   function automatic logic signed [ACC_BIT_DEPTH-1:0] ext_feature(
      input logic signed [SAMPLE_BIT_DEPTH-1:0] f
   );
      return {{(ACC_BIT_DEPTH-SAMPLE_BIT_DEPTH){f[SAMPLE_BIT_DEPTH-1]}}, f};
   endfunction

   function automatic logic signed [ACC_BIT_DEPTH-1:0] ext_bias(
      input logic signed [BIAS_BIT_DEPTH-1:0] b
   );
      return {{(ACC_BIT_DEPTH-BIAS_BIT_DEPTH){b[BIAS_BIT_DEPTH-1]}}, b};
   endfunction

   // Both operands are sign-extended to the product width, so the low
   // PROD_W bits of the unsigned multiply equal the signed product.
   function automatic logic signed [ACC_BIT_DEPTH-1:0] beat_term(
      input logic signed [SAMPLE_BIT_DEPTH-1:0] f,
      input logic signed [COEFF_BIT_DEPTH-1:0]  c,
      input logic                               one
   );
      logic signed [PROD_W-1:0] prod;
      prod = {{COEFF_BIT_DEPTH{f[SAMPLE_BIT_DEPTH-1]}}, f}
           * {{SAMPLE_BIT_DEPTH{c[COEFF_BIT_DEPTH-1]}}, c};
      if (one) return ext_feature(f);
      return {{(ACC_BIT_DEPTH-PROD_W){prod[PROD_W-1]}}, prod};
   endfunction

   // Stage p0: beat datapath feeding the accumulator
   always_comb begin
      feat_sel = sample_p0[int'(beat_p0)*SAMPLE_BIT_DEPTH +: SAMPLE_BIT_DEPTH];
      acc_base = (beat_p0 == '0) ? ext_bias(bus.bias) : acc_p0;
      acc_sum  = acc_base + beat_term(feat_sel, bus.coeff, bus.is_one);
   end

   always_comb begin
      state_nxt  = state_p0;
      sample_nxt = sample_p0;
      acc_nxt    = acc_p0;
      beat_nxt   = beat_p0;
      vld_nxt    = 1'b0;
      dir_nxt    = dir_p1;
      unique case (state_p0)
         IDLE: begin
            if (bus.in_valid) begin
               sample_nxt = bus.features;
               acc_nxt    = '0;
               beat_nxt   = '0;
               state_nxt  = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.tree_done) begin
               acc_nxt   = '0;
               beat_nxt  = '0;
               state_nxt = IDLE;
            end else if (bus.coeff_valid) begin
               acc_nxt = acc_sum;
               if (beat_p0 == LAST_BEAT) begin
                  beat_nxt  = '0;
                  vld_nxt   = 1'b1;
                  dir_nxt   = ~acc_sum[ACC_BIT_DEPTH-1];
                  state_nxt = DECIDE;
               end else begin
                  beat_nxt = beat_p0 + BEAT_W'(1);
               end
            end
         end
         DECIDE: begin
            beat_nxt = '0;
            if (bus.tree_done) begin
               acc_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               state_nxt = ACCUM;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stage p1: registered state and decision outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_p0  <= IDLE;
         sample_p0 <= '0;
         acc_p0    <= '0;
         beat_p0   <= '0;
         vld_p1    <= 1'b0;
         dir_p1    <= 1'b0;
      end else begin
         state_p0  <= state_nxt;
         sample_p0 <= sample_nxt;
         acc_p0    <= acc_nxt;
         beat_p0   <= beat_nxt;
         vld_p1    <= vld_nxt;
         dir_p1    <= dir_nxt;
      end
   end

   assign bus.in_ready        = (state_p0 == IDLE);
   assign bus.next            = vld_p1;
   assign bus.child_direction = dir_p1;

   a_next_only_in_decide: assert property (
      @(posedge clk) disable iff (!reset) vld_p1 |-> (state_p0 == DECIDE));

   a_beat_in_range: assert property (
      @(posedge clk) disable iff (!reset) beat_p0 <= LAST_BEAT);

endmodule

// File: tb/tb_node_eval.sv
// Directed bench for node_eval with a plain-arithmetic node model and a
// per-cycle compare of next, child_direction and in_ready.
module tb_node_eval;
   localparam int F  = 3;
   localparam int SW = 8;
   localparam int CW = 4;
   localparam int BW = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   node_eval_if #(.FEATURES(F), .SAMPLE_BIT_DEPTH(SW),
                  .COEFF_BIT_DEPTH(CW), .BIAS_BIT_DEPTH(BW)) bus ();

   node_eval #(.FEATURES(F), .COEFF_BIT_DEPTH(CW),
               .BIAS_BIT_DEPTH(BW), .SAMPLE_BIT_DEPTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic signed [31:0] act,
                               logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Stimulus mirror and model state
   int cur_f [F];
   int cur_c, cur_b;
   bit cur_one;
   int m_f [F];
   int m_sum, m_nbeat, m_last;
   bit m_held, m_next, m_dir;
   bit started = 1'b0;
   int npulse  = 0;

   task automatic tick();
      bit was;
      int term;
      @(posedge clk);
      #1;
      was    = m_next;
      m_next = 1'b0;
      if (reset == 1'b0) begin
         m_held = 1'b0; m_dir = 1'b0; m_nbeat = 0; m_sum = 0;
      end else if (!m_held) begin
         if (bus.in_valid) begin
            m_held = 1'b1; m_f = cur_f; m_nbeat = 0; m_sum = 0;
         end
      end else if (bus.tree_done) begin
         m_held = 1'b0; m_nbeat = 0; m_sum = 0;
      end else if (was) begin
         m_nbeat = 0;
      end else if (bus.coeff_valid) begin
         term    = cur_one ? m_f[m_nbeat] : m_f[m_nbeat] * cur_c;
         m_sum   = ((m_nbeat == 0) ? cur_b : m_sum) + term;
         m_nbeat = m_nbeat + 1;
         if (m_nbeat == F) begin
            m_next = 1'b1; m_dir = (m_sum >= 0); m_last = m_sum; m_nbeat = 0;
         end
      end
      started = 1'b1;
   endtask

   task automatic drive(bit iv, bit cv, int c, bit one, int b, bit td);
      bus.in_valid    = iv;
      bus.coeff_valid = cv;
      bus.coeff       = CW'(c);
      bus.is_one      = one;
      bus.bias        = BW'(b);
      bus.tree_done   = td;
      cur_c = c; cur_b = b; cur_one = one;
      tick();
   endtask

   task automatic set_sample(int a0, int a1, int a2);
      cur_f[0] = a0; cur_f[1] = a1; cur_f[2] = a2;
      bus.features = {SW'(a2), SW'(a1), SW'(a0)};
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic beat(int c, bit one, int b);
      drive(0, 1, c, one, b, 0);
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("next", bus.next, m_next);
         chk("child_direction", bus.child_direction, m_dir);
         chk("in_ready", bus.in_ready, !m_held);
         if (bus.next === 1'b1) npulse++;
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      reset = 1'b0;
      set_sample(0, 0, 0);
      idle(2);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_next", bus.next, 0);
      chk("rst_dir", bus.child_direction, 0);
      reset = 1'b1;
      idle(1);
      chk("post_rst_ready", bus.in_ready, 1);

      // -20 + 10*2 + (-5) + 3*(-1) = -8 ; coeff in IDLE ignored
      drive(0, 1, 5, 0, 0, 0);
      set_sample(10, -5, 3);
      drive(1, 0, 0, 0, 0, 0);
      beat(2, 0, -20);
      beat(0, 1, 100);
      beat(-1, 0, 100);
      chk("b1_next", bus.next, 1);
      chk("b1_dir", bus.child_direction, 0);
      chk("b1_model_sum", m_last, -8);
      idle(1);
      drive(0, 0, 0, 0, 0, 1);

      // Bias -12 lands exactly on zero
      drive(1, 0, 0, 0, 0, 0);
      beat(2, 0, -12);
      beat(0, 1, 0);
      beat(-1, 0, 0);
      chk("b2_next", bus.next, 1);
      chk("b2_dir", bus.child_direction, 1);
      chk("b2_model_sum", m_last, 0);
      idle(1);
      drive(0, 0, 0, 0, 0, 1);

      // Extreme operands: 511 + 3*1024
      set_sample(-128, -128, -128);
      drive(1, 0, 0, 0, 0, 0);
      beat(-8, 0, 511);
      beat(-8, 0, 0);
      beat(-8, 0, 0);
      chk("b3_dir", bus.child_direction, 1);
      chk("b3_model_sum", m_last, 3583);
      idle(1);
      drive(0, 0, 0, 0, 0, 1);

      // Two nodes on one sample with stalls; DECIDE ignores in_valid/coeff
      p0 = npulse;
      set_sample(10, -5, 3);
      drive(1, 0, 0, 0, 0, 0);
      beat(2, 0, -20); idle(2);
      beat(0, 1, 0);   idle(2);
      beat(-1, 0, 0);
      chk("b4_n1_dir", bus.child_direction, 0);
      set_sample(1, 1, 1);
      drive(1, 1, 7, 0, 300, 0);
      beat(2, 0, -12); idle(2);
      beat(0, 1, 0);   idle(2);
      beat(-1, 0, 0);
      chk("b4_n2_dir", bus.child_direction, 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("b4_pulses", npulse - p0, 2);
      chk("b4_ready_after_done", bus.in_ready, 1);

      // tree_done on beat 1 aborts the node
      p0 = npulse;
      set_sample(1, 2, 3);
      drive(1, 0, 0, 0, 0, 0);
      beat(1, 0, -7);
      drive(0, 1, 1, 0, 0, 1);
      chk("b5_ready", bus.in_ready, 1);
      idle(2);
      chk("b5_pulses", npulse - p0, 0);
      drive(1, 0, 0, 0, 0, 0);
      beat(1, 0, -7);
      beat(1, 0, 0);
      beat(1, 0, 0);
      chk("b5_dir", bus.child_direction, 0);
      chk("b5_model_sum", m_last, -1);
      idle(1);
      drive(0, 0, 0, 0, 0, 1);

      // Reset mid-node, then a clean node; in_valid during reset is lost
      set_sample(4, 4, 4);
      drive(1, 0, 0, 0, 0, 0);
      beat(0, 1, 0);
      beat(0, 1, 0);
      beat(0, 1, 0);
      chk("b6_pre_dir", bus.child_direction, 1);
      idle(1);
      p0 = npulse;
      beat(0, 1, 0);
      beat(0, 1, 0);
      set_sample(2, 3, -1);
      reset = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      reset = 1'b1;
      chk("b6_rst_dir", bus.child_direction, 0);
      chk("b6_rst_ready", bus.in_ready, 1);
      idle(2);
      chk("b6_pulses", npulse - p0, 0);
      drive(1, 0, 0, 0, 0, 0);
      beat(3, 0, 10);
      beat(-2, 0, 0);
      beat(7, 0, 0);
      chk("b6_next", bus.next, 1);
      chk("b6_dir", bus.child_direction, 1);
      chk("b6_model_sum", m_last, 3);
      idle(1);
      drive(0, 0, 0, 0, 0, 1);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
